// File: rtl/branch_trace_monitor.sv
// branch_trace_monitor: circular retire-trace buffer that arms, waits for a
// branch trigger, captures POST_TRIG more retires, then freezes for read-back.
// Optional feature macro: BRANCH_TRACE_MONITOR_CYCLE_STAMP_EN adds a 32-bit
// free-running cycle stamp per entry, read on rd_stamp.
module branch_trace_monitor #(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned POST_TRIG = 8,
    parameter int unsigned PC_W      = 64,
    parameter int unsigned TRIG_MODE = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     arm,
    input  logic                     valid,
    input  logic [PC_W-1:0]          pc,
    input  logic [31:0]              instr,
    input  logic                     is_branch,
    input  logic                     taken,
    input  logic                     link,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic [PC_W-1:0]          rd_pc,
    output logic [31:0]              rd_instr,
    output logic [2:0]               rd_flags,
    output logic [1:0]               state,
    output logic [$clog2(DEPTH):0]   count,
    output logic [$clog2(DEPTH)-1:0] trig_pos
`ifdef BRANCH_TRACE_MONITOR_CYCLE_STAMP_EN
    ,
    output logic [31:0]              rd_stamp
`endif
);

    localparam int unsigned AW        = $clog2(DEPTH);
    localparam int unsigned CW        = AW + 1;
    localparam int unsigned POST_LAST = (POST_TRIG > 0) ? POST_TRIG - 1 : 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] oldest_q, oldest_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] post_cnt_q, post_cnt_d;
    logic [AW-1:0] trig_abs_q, trig_abs_d;
    logic          trig_vld_q, trig_vld_d;
    logic [AW-1:0] trig_pos_q, trig_pos_d;

    logic [PC_W-1:0] rd_pc_q;
    logic [31:0]     rd_instr_q;
    logic [2:0]      rd_flags_q;

    logic [PC_W-1:0] mem_pc    [DEPTH];
    logic [31:0]     mem_instr [DEPTH];
    logic [2:0]      mem_flags [DEPTH];

    logic          trig_match;
    logic          capture;
    logic          trig_hit;
    logic          post_hit;
    logic [AW-1:0] rd_addr;
    logic          rd_hit;

    // Trigger qualifier selected by TRIG_MODE
    generate
        if (TRIG_MODE == 0) begin : g_trig_any
            assign trig_match = is_branch;
        end else if (TRIG_MODE == 2) begin : g_trig_link
            assign trig_match = is_branch & taken & link;
        end else begin : g_trig_taken
            assign trig_match = is_branch & taken;
        end
    endgenerate

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; arm restarts from any state
    always_comb begin
        state_d = state_q;
        if (arm) begin
            state_d = ST_ARMED;
        end else begin
            case (state_q)
                ST_ARMED: if (trig_hit) state_d = (POST_TRIG == 0) ? ST_DONE : ST_POST;
                ST_POST:  if (post_hit) state_d = ST_DONE;
                default:  state_d = state_q;
            endcase
        end
    end

    // FSM outputs: capture strobe, trigger hit, last post-trigger write
    always_comb begin
        capture  = 1'b0;
        trig_hit = 1'b0;
        post_hit = 1'b0;
        if (!arm && valid) begin
            case (state_q)
                ST_ARMED: begin
                    capture  = 1'b1;
                    trig_hit = trig_match;
                end
                ST_POST: begin
                    capture  = 1'b1;
                    post_hit = (post_cnt_q == AW'(POST_LAST));
                end
                default: ;
            endcase
        end
    end

    // Pointer, count and trigger bookkeeping
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        oldest_d   = oldest_q;
        count_d    = count_q;
        post_cnt_d = post_cnt_q;
        trig_abs_d = trig_abs_q;
        trig_vld_d = trig_vld_q;
        if (arm) begin
            wr_ptr_d   = '0;
            oldest_d   = '0;
            count_d    = '0;
            post_cnt_d = '0;
            trig_abs_d = '0;
            trig_vld_d = 1'b0;
        end else if (capture) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            if (count_q == CW'(DEPTH)) begin
                oldest_d = oldest_q + AW'(1);
            end else begin
                count_d = count_q + CW'(1);
            end
            if (trig_hit) begin
                trig_abs_d = wr_ptr_q;
                trig_vld_d = 1'b1;
                post_cnt_d = '0;
            end else if (state_q == ST_POST) begin
                post_cnt_d = post_cnt_q + AW'(1);
            end
        end
        trig_pos_d = trig_vld_d ? (trig_abs_d - oldest_d) : '0;
    end

    // Bookkeeping registers
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            oldest_q   <= '0;
            count_q    <= '0;
            post_cnt_q <= '0;
            trig_abs_q <= '0;
            trig_vld_q <= 1'b0;
            trig_pos_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            oldest_q   <= oldest_d;
            count_q    <= count_d;
            post_cnt_q <= post_cnt_d;
            trig_abs_q <= trig_abs_d;
            trig_vld_q <= trig_vld_d;
            trig_pos_q <= trig_pos_d;
        end
    end

    // Trace storage write; contents are left as-is on reset
    always_ff @(posedge clock) begin
        if (capture && !reset) begin
            mem_pc[wr_ptr_q]    <= pc;
            mem_instr[wr_ptr_q] <= instr;
            mem_flags[wr_ptr_q] <= {is_branch, taken, link};
        end
    end

    assign rd_addr = oldest_q + rd_idx;
    assign rd_hit  = (CW'(rd_idx) < count_q);

    // Registered read relative to the oldest entry; out-of-range reads return zero
    always_ff @(posedge clock) begin
        if (reset || !rd_hit) begin
            rd_pc_q    <= '0;
            rd_instr_q <= '0;
            rd_flags_q <= '0;
        end else begin
            rd_pc_q    <= mem_pc[rd_addr];
            rd_instr_q <= mem_instr[rd_addr];
            rd_flags_q <= mem_flags[rd_addr];
        end
    end

`ifdef BRANCH_TRACE_MONITOR_CYCLE_STAMP_EN
    logic [31:0] cyc_q;
    logic [31:0] mem_stamp [DEPTH];
    logic [31:0] rd_stamp_q;

    // Free-running cycle counter
    always_ff @(posedge clock) begin
        if (reset) begin
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_q + 32'd1;
        end
    end

    // Stamp storage alongside each captured entry
    always_ff @(posedge clock) begin
        if (capture && !reset) begin
            mem_stamp[wr_ptr_q] <= cyc_q;
        end
    end

    // Stamp read with the same latency as the other read data
    always_ff @(posedge clock) begin
        if (reset || !rd_hit) begin
            rd_stamp_q <= '0;
        end else begin
            rd_stamp_q <= mem_stamp[rd_addr];
        end
    end

    assign rd_stamp = rd_stamp_q;
`endif

    assign state    = state_q;
    assign count    = count_q;
    assign trig_pos = trig_pos_q;
    assign rd_pc    = rd_pc_q;
    assign rd_instr = rd_instr_q;
    assign rd_flags = rd_flags_q;

endmodule

// File: tb/tb_branch_trace_monitor.sv
// Scoreboarded bench for branch_trace_monitor: two instances (TRIG_MODE 1 and 2)
// share stimulus; a history-based reference model predicts every cycle's outputs.
module tb_branch_trace_monitor;

    localparam int unsigned DEPTH     = 16;
    localparam int unsigned POST_TRIG = 8;
    localparam int unsigned AW        = 4;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic [2:0]  flags;
        logic [31:0] stamp;
    } entry_t;

    typedef struct packed {
        logic [63:0] rd_pc;
        logic [31:0] rd_instr;
        logic [2:0]  rd_flags;
        logic [31:0] rd_stamp;
        logic [1:0]  st;
        logic [4:0]  cnt;
        logic [3:0]  tpos;
    } obs_t;

    logic          clock;
    logic          reset, arm, valid, is_branch, taken, link;
    logic [63:0]   pc;
    logic [31:0]   instr;
    logic [AW-1:0] rd_idx;

    logic [63:0]   rd_pc0, rd_pc1;
    logic [31:0]   rd_instr0, rd_instr1;
    logic [2:0]    rd_flags0, rd_flags1;
    logic [1:0]    state0, state1;
    logic [AW:0]   count0, count1;
    logic [AW-1:0] trig_pos0, trig_pos1;
    logic [31:0]   rd_stamp0, rd_stamp1;

    branch_trace_monitor #(.DEPTH(DEPTH), .POST_TRIG(POST_TRIG), .PC_W(64), .TRIG_MODE(1)) dut0 (
        .clock(clock), .reset(reset), .arm(arm), .valid(valid), .pc(pc), .instr(instr),
        .is_branch(is_branch), .taken(taken), .link(link), .rd_idx(rd_idx),
        .rd_pc(rd_pc0), .rd_instr(rd_instr0), .rd_flags(rd_flags0),
        .state(state0), .count(count0), .trig_pos(trig_pos0)
`ifdef BRANCH_TRACE_MONITOR_CYCLE_STAMP_EN
        , .rd_stamp(rd_stamp0)
`endif
    );

    branch_trace_monitor #(.DEPTH(DEPTH), .POST_TRIG(POST_TRIG), .PC_W(64), .TRIG_MODE(2)) dut1 (
        .clock(clock), .reset(reset), .arm(arm), .valid(valid), .pc(pc), .instr(instr),
        .is_branch(is_branch), .taken(taken), .link(link), .rd_idx(rd_idx),
        .rd_pc(rd_pc1), .rd_instr(rd_instr1), .rd_flags(rd_flags1),
        .state(state1), .count(count1), .trig_pos(trig_pos1)
`ifdef BRANCH_TRACE_MONITOR_CYCLE_STAMP_EN
        , .rd_stamp(rd_stamp1)
`endif
    );

`ifndef BRANCH_TRACE_MONITOR_CYCLE_STAMP_EN
    assign rd_stamp0 = '0;
    assign rd_stamp1 = '0;
`endif

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int vectors;
    int miscompares;

    // Reference model: full capture history since the last arm, per instance
    entry_t      hist [2][$];
    int          m_state [2];
    int          m_n [2];
    int          m_trig_seq [2];
    int          m_rem [2];
    bit          m_trig [2];
    int unsigned m_cyc;

    obs_t sb [$];
    bit   chk_req;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic bit is_trig(int m, logic [2:0] fl);
        if (m == 0) return fl[2] & fl[1];
        return fl == 3'b111;
    endfunction

    function automatic obs_t model_cycle(int m, bit a, bit v, bit r, entry_t e, logic [3:0] ri);
        obs_t o;
        int   size;
        int   base;
        int   idx;
        o    = '0;
        idx  = int'(ri);
        size = (m_n[m] < int'(DEPTH)) ? m_n[m] : int'(DEPTH);
        base = m_n[m] - size;
        if (!r && idx < size) begin
            o.rd_pc    = hist[m][base + idx].pc;
            o.rd_instr = hist[m][base + idx].instr;
            o.rd_flags = hist[m][base + idx].flags;
            o.rd_stamp = hist[m][base + idx].stamp;
        end
        if (r) begin
            m_state[m] = 0;
            hist[m].delete();
            m_n[m]    = 0;
            m_trig[m] = 1'b0;
        end else if (a) begin
            m_state[m] = 1;
            hist[m].delete();
            m_n[m]    = 0;
            m_trig[m] = 1'b0;
        end else if (v && (m_state[m] == 1 || m_state[m] == 2)) begin
            hist[m].push_back(e);
            m_n[m]++;
            if (m_state[m] == 1 && is_trig(m, e.flags)) begin
                m_trig[m]     = 1'b1;
                m_trig_seq[m] = m_n[m] - 1;
                if (POST_TRIG == 0) begin
                    m_state[m] = 3;
                end else begin
                    m_state[m] = 2;
                    m_rem[m]   = int'(POST_TRIG);
                end
            end else if (m_state[m] == 2) begin
                m_rem[m]--;
                if (m_rem[m] == 0) m_state[m] = 3;
            end
        end
        size   = (m_n[m] < int'(DEPTH)) ? m_n[m] : int'(DEPTH);
        o.st   = 2'(m_state[m]);
        o.cnt  = 5'(size);
        o.tpos = m_trig[m] ? 4'(m_trig_seq[m] - (m_n[m] - size)) : 4'd0;
        return o;
    endfunction

    task automatic drive(bit a, bit v, bit r, logic [63:0] p, logic [31:0] ins,
                         logic [2:0] fl, logic [3:0] ri);
        entry_t e;
        arm    = a;
        valid  = v;
        reset  = r;
        pc     = p;
        instr  = ins;
        {is_branch, taken, link} = fl;
        rd_idx = ri;
        e.pc    = p;
        e.instr = ins;
        e.flags = fl;
        e.stamp = m_cyc;
        for (int m = 0; m < 2; m++) sb.push_back(model_cycle(m, a, v, r, e, ri));
        m_cyc   = r ? 0 : m_cyc + 1;
        chk_req = 1'b1;
        @(negedge clock);
    endtask

    task automatic idle(logic [3:0] ri);
        drive(1'b0, 1'b0, 1'b0, 64'd0, 32'd0, 3'b000, ri);
    endtask

    task automatic retire(logic [63:0] p, logic [2:0] fl);
        drive(1'b0, 1'b1, 1'b0, p, $urandom, fl, 4'($urandom));
    endtask

    // Monitor: compares the DUT outputs after every driven edge against the scoreboard
    initial begin
        bit   fire;
        obs_t e;
        obs_t act;
        forever begin
            @(posedge clock);
            fire = chk_req;
            @(negedge clock);
            if (fire) begin
                if (sb.size() < 2) begin
                    chk("sb_underflow", 64'(sb.size()), 64'd2);
                end else begin
                    for (int m = 0; m < 2; m++) begin
                        e = sb.pop_front();
                        if (m == 0)
                            act = '{rd_pc0, rd_instr0, rd_flags0, rd_stamp0, state0, count0, trig_pos0};
                        else
                            act = '{rd_pc1, rd_instr1, rd_flags1, rd_stamp1, state1, count1, trig_pos1};
                        chk($sformatf("u%0d.rd_pc", m), act.rd_pc, e.rd_pc);
                        chk($sformatf("u%0d.rd_instr", m), 64'(act.rd_instr), 64'(e.rd_instr));
                        chk($sformatf("u%0d.rd_flags", m), 64'(act.rd_flags), 64'(e.rd_flags));
                        chk($sformatf("u%0d.state", m), 64'(act.st), 64'(e.st));
                        chk($sformatf("u%0d.count", m), 64'(act.cnt), 64'(e.cnt));
                        chk($sformatf("u%0d.trig_pos", m), 64'(act.tpos), 64'(e.tpos));
`ifdef BRANCH_TRACE_MONITOR_CYCLE_STAMP_EN
                        chk($sformatf("u%0d.rd_stamp", m), 64'(act.rd_stamp), 64'(e.rd_stamp));
`endif
                    end
                end
            end
        end
    end

    // Stimulus: directed scenarios, then randomized traffic
    initial begin
        vectors     = 0;
        miscompares = 0;
        chk_req     = 1'b0;
        m_cyc       = 0;
        for (int m = 0; m < 2; m++) begin
            m_state[m] = 0; m_n[m] = 0; m_trig[m] = 1'b0; m_trig_seq[m] = 0; m_rem[m] = 0;
        end
        reset = 1'b1; arm = 1'b0; valid = 1'b0; pc = '0; instr = '0;
        is_branch = 1'b0; taken = 1'b0; link = 1'b0; rd_idx = '0;
        @(negedge clock);

        drive(1'b0, 1'b0, 1'b1, 64'd0, 32'd0, 3'b000, 4'd0);
        chk("reset_state", 64'(state0), 64'd0);
        chk("reset_count", 64'(count0), 64'd0);

        // wrap-around capture with late trigger
        drive(1'b1, 1'b0, 1'b0, 64'd0, 32'd0, 3'b000, 4'd0);
        for (int i = 0; i < 30; i++) retire(64'h1000 + 64'(4 * i), 3'b000);
        retire(64'h40, 3'b110);
        for (int i = 0; i < 8; i++) retire(64'h2000 + 64'(4 * i), 3'b000);
        idle(4'd7);
        chk("wrap_state", 64'(state0), 64'd3);
        chk("wrap_count", 64'(count0), 64'd16);
        chk("wrap_trig_pos", 64'(trig_pos0), 64'd7);
        chk("wrap_rd_pc", rd_pc0, 64'h40);
        chk("wrap_rd_flags", 64'(rd_flags0), 64'b110);

        // frozen in DONE, then re-arm for a fresh capture
        retire(64'h5555, 3'b110);
        drive(1'b1, 1'b0, 1'b0, 64'd0, 32'd0, 3'b000, 4'd0);
        retire(64'h300, 3'b110);
        for (int i = 0; i < 8; i++) retire(64'h3000 + 64'(4 * i), 3'b000);
        idle(4'd0);
        chk("rearm_state", 64'(state0), 64'd3);
        chk("rearm_count", 64'(count0), 64'd9);
        chk("rearm_trig_pos", 64'(trig_pos0), 64'd0);
        chk("rearm_rd_pc", rd_pc0, 64'h300);

        // early trigger on a BL
        drive(1'b1, 1'b0, 1'b0, 64'd0, 32'd0, 3'b000, 4'd0);
        retire(64'h10, 3'b000);
        retire(64'h14, 3'b000);
        retire(64'h100, 3'b111);
        for (int i = 0; i < 8; i++) retire(64'h4000 + 64'(4 * i), 3'b000);
        idle(4'd2);
        chk("early_count", 64'(count0), 64'd11);
        chk("early_trig_pos", 64'(trig_pos0), 64'd2);
        chk("early_rd_flags", 64'(rd_flags0), 64'b111);
        chk("early_rd_pc", rd_pc0, 64'h100);
        idle(4'd12);
        chk("early_oob_pc", rd_pc0, 64'd0);
        chk("early_oob_instr", 64'(rd_instr0), 64'd0);
        chk("early_oob_flags", 64'(rd_flags0), 64'd0);

        // link-only trigger skips a plain taken B
        drive(1'b1, 1'b0, 1'b0, 64'd0, 32'd0, 3'b000, 4'd0);
        retire(64'h70, 3'b000);
        retire(64'h80, 3'b110);
        retire(64'h90, 3'b111);
        for (int i = 0; i < 8; i++) retire(64'h5000 + 64'(4 * i), 3'b000);
        idle(4'd1);
        chk("link_trig_pos", 64'(trig_pos1), 64'd2);
        chk("link_count", 64'(count1), 64'd11);
        chk("link_state", 64'(state1), 64'd3);
        chk("link_b_pc", rd_pc1, 64'h80);
        chk("link_b_flags", 64'(rd_flags1), 64'b110);
        chk("taken_trig_pos", 64'(trig_pos0), 64'd1);
        idle(4'd2);
        chk("link_bl_pc", rd_pc1, 64'h90);

        // reset together with arm while in POST
        drive(1'b1, 1'b0, 1'b0, 64'd0, 32'd0, 3'b000, 4'd0);
        retire(64'h1f0, 3'b000);
        retire(64'h200, 3'b111);
        retire(64'h204, 3'b000);
        retire(64'h208, 3'b000);
        chk("pre_reset_state", 64'(state0), 64'd2);
        drive(1'b1, 1'b1, 1'b1, 64'h20c, 32'd1, 3'b111, 4'd0);
        chk("midrst_state", 64'(state0), 64'd0);
        chk("midrst_count", 64'(count0), 64'd0);
        chk("midrst_trig_pos", 64'(trig_pos0), 64'd0);
        chk("midrst_rd_pc", rd_pc0, 64'd0);
        chk("midrst_rd_instr", 64'(rd_instr0), 64'd0);
        chk("midrst_rd_flags", 64'(rd_flags0), 64'd0);
        idle(4'd0);
        chk("postrst_rd_pc", rd_pc0, 64'd0);

`ifdef BRANCH_TRACE_MONITOR_CYCLE_STAMP_EN
        begin
            logic [31:0] s0;
            logic [31:0] s1;
            drive(1'b0, 1'b0, 1'b1, 64'd0, 32'd0, 3'b000, 4'd0);
            drive(1'b1, 1'b0, 1'b0, 64'd0, 32'd0, 3'b000, 4'd0);
            for (int i = 0; i < 3; i++) idle(4'd0);
            retire(64'h600, 3'b000);
            for (int i = 0; i < 3; i++) idle(4'd0);
            retire(64'h604, 3'b000);
            idle(4'd0);
            s0 = rd_stamp0;
            idle(4'd1);
            s1 = rd_stamp0;
            chk("stamp_delta", 64'(s1 - s0), 64'd4);
        end
`endif

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit         r;
            bit         a;
            bit         v;
            logic [2:0] fl;
            r  = ($urandom_range(0, 199) == 0);
            a  = ($urandom_range(0, 39) == 0);
            v  = ($urandom_range(0, 3) != 0);
            fl = {($urandom_range(0, 5) == 0), 1'($urandom), 1'($urandom)};
            drive(a, v, r, {$urandom, $urandom}, $urandom, fl, 4'($urandom));
        end

        chk_req = 1'b0;
        @(posedge clock);
        @(negedge clock);
        #1;
        chk("sb_drain", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
